// File: rtl/io_uart_in_if.sv
// dma_io register bus seen by io_uart_in: word-addressed writes, strobed reads,
// and a daisy-chained read-data path (rdata_in -> rdata).
interface io_uart_in_if;
    logic        we;
    logic [13:0] wadr;
    logic [31:0] wdata;
    logic [13:0] radr;
    logic        radr_en;
    logic [31:0] rdata_in;
    logic [31:0] rdata;

    modport master (
        output we, wadr, wdata, radr, radr_en, rdata_in,
        input  rdata
    );

    modport slave (
        input  we, wadr, wdata, radr, radr_en, rdata_in,
        output rdata
    );
endinterface

// File: rtl/io_uart_in.sv
// UART receive FIFO with dma_io data/status registers and a level RX interrupt.
// Optional macro IO_UART_IN_IRQ_EN adds the irq_en control bit and drives rx_irq.
module io_uart_in #(
    parameter logic [13:0] DATA_ADR    = 14'h3E00,
    parameter logic [13:0] STAT_ADR    = 14'h3E01,
    parameter int unsigned FDEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_char,
    input  logic             rx_char_we,
    io_uart_in_if.slave      dma_io,
    output logic             rx_irq
);

    localparam int unsigned DEPTH = 1 << FDEPTH_LOG2;
    localparam int unsigned CNT_W = FDEPTH_LOG2 + 1;

    logic [7:0]             fifo_mem [DEPTH];
    logic [FDEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]       count, count_nxt;
    logic                   overrun, overrun_nxt;
    logic [31:0]            rd_reg;
    logic                   rd_hit;
    logic                   irq_bit;

    logic data_hit, stat_hit, wr_stat, flush, ovr_clr;
    logic full, not_empty, push, pop, ovr_evt;
    logic [31:0] status;
    logic unused_wdata;

    assign data_hit  = dma_io.radr_en && (dma_io.radr == DATA_ADR);
    assign stat_hit  = dma_io.radr_en && (dma_io.radr == STAT_ADR);
    assign wr_stat   = dma_io.we && (dma_io.wadr == STAT_ADR);
    assign flush     = wr_stat && dma_io.wdata[3];
    assign ovr_clr   = wr_stat && dma_io.wdata[2];

    assign full      = (count == CNT_W'(DEPTH));
    assign not_empty = (count != '0);

    // A pop frees the slot, so a push into a full FIFO still lands; flush drops it silently.
    assign pop       = data_hit && not_empty;
    assign push      = rx_char_we && (!full || pop) && !flush;
    assign ovr_evt   = rx_char_we && full && !pop && !flush;

    assign status = {19'd0, 9'(count), irq_bit, overrun, full, not_empty};

    assign unused_wdata = ^{dma_io.wdata[31:4], dma_io.wdata[1:0]};

    always_comb begin
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        count_nxt   = count;
        overrun_nxt = overrun;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + 1'b1;
            if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
            if (push && !pop)      count_nxt = count + 1'b1;
            else if (pop && !push) count_nxt = count - 1'b1;
        end
        // A new overrun in the same cycle as a clear keeps the flag set.
        if (ovr_evt)      overrun_nxt = 1'b1;
        else if (ovr_clr) overrun_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_char;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            rd_reg  <= '0;
            rd_hit  <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count   <= count_nxt;
            overrun <= overrun_nxt;
            rd_hit  <= data_hit || stat_hit;
            if (data_hit)
                rd_reg <= not_empty ? {23'd0, 1'b1, fifo_mem[rd_ptr]} : '0;
            else if (stat_hit)
                rd_reg <= status;
        end
    end

    assign dma_io.rdata = rd_hit ? rd_reg : dma_io.rdata_in;

`ifdef IO_UART_IN_IRQ_EN
    logic irq_en, irq_en_nxt;

    assign irq_en_nxt = wr_stat ? dma_io.wdata[0] : irq_en;
    assign irq_bit    = irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 1'b0;
            rx_irq <= 1'b0;
        end else begin
            irq_en <= irq_en_nxt;
            rx_irq <= irq_en_nxt && (count_nxt != '0);
        end
    end
`else
    assign irq_bit = 1'b0;
    assign rx_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_io_uart_in.sv
// Scoreboard bench for io_uart_in: a queue model of the FIFO predicts every read.
module tb_io_uart_in;

    localparam logic [13:0] DATA_ADR = 14'h3E00;
    localparam logic [13:0] STAT_ADR = 14'h3E01;
    localparam int unsigned DEPTH    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_char;
    logic       rx_char_we;
    logic       rx_irq;

    io_uart_in_if ifc ();

    io_uart_in #(
        .DATA_ADR   (DATA_ADR),
        .STAT_ADR   (STAT_ADR),
        .FDEPTH_LOG2(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_char   (rx_char),
        .rx_char_we(rx_char_we),
        .dma_io    (ifc.slave),
        .rx_irq    (rx_irq)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  m_q [$];
    logic        m_ovr;
    logic        m_irq;
    logic [31:0] sb_q [$];

`ifdef IO_UART_IN_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One bus cycle: inputs set at negedge, held across posedge, released 1ns after it.
    task automatic drive(input logic cw, input logic [7:0] c,
                         input logic ww, input logic [13:0] wa, input logic [31:0] wd,
                         input logic re, input logic [13:0] ra);
        @(negedge clk);
        rx_char_we     = cw;
        rx_char        = c;
        ifc.we         = ww;
        ifc.wadr       = wa;
        ifc.wdata      = wd;
        ifc.radr_en    = re;
        ifc.radr       = ra;
        @(posedge clk);
        #1;
        rx_char_we  = 1'b0;
        ifc.we      = 1'b0;
        ifc.radr_en = 1'b0;
    endtask

    task automatic sb_compare(input string tag);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty got=0x%08h expected=none", tag, ifc.rdata);
        end else begin
            exp = sb_q.pop_front();
            check(tag, ifc.rdata, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int unsigned n;
        n = m_q.size();
        return {19'd0, 9'(n), m_irq & IRQ_BUILD, m_ovr, n == DEPTH, n != 0};
    endfunction

    function automatic logic [31:0] model_pop();
        if (m_q.size() == 0) return 32'd0;
        return {23'd0, 1'b1, m_q.pop_front()};
    endfunction

    task automatic push(input logic [7:0] b);
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovr = 1'b1;
        drive(1'b1, b, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd_data(input string tag);
        sb_q.push_back(model_pop());
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, DATA_ADR);
        sb_compare(tag);
    endtask

    task automatic rd_stat(input string tag);
        sb_q.push_back(model_status());
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, STAT_ADR);
        sb_compare(tag);
    endtask

    task automatic wr_stat(input logic [31:0] d);
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_q.delete();
        m_irq = d[0];
        drive(1'b0, '0, 1'b1, STAT_ADR, d, 1'b0, '0);
    endtask

    task automatic push_pop(input string tag, input logic [7:0] b);
        sb_q.push_back(model_pop());
        m_q.push_back(b);
        drive(1'b1, b, 1'b0, '0, '0, 1'b1, DATA_ADR);
        sb_compare(tag);
    endtask

    initial begin
        rst = 1'b1;
        rx_char = '0; rx_char_we = 1'b0;
        ifc.we = 1'b0; ifc.wadr = '0; ifc.wdata = '0;
        ifc.radr = '0; ifc.radr_en = 1'b0; ifc.rdata_in = 32'h1234_5678;
        m_ovr = 1'b0; m_irq = 1'b0;
        #3;
        check("rst_rdata_pass", ifc.rdata, 32'h1234_5678);
        check("rst_irq", {31'd0, rx_irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_stat("stat_after_rst");

        // Basic ordering and empty read
        push(8'h41);
        push(8'h42);
        rd_data("data_0x41");
        rd_data("data_0x42");
        rd_data("data_empty");

        // Overflow: 17th byte dropped, overrun sticky
        for (int unsigned i = 0; i < 17; i++) push(8'(8'h60 + i));
        rd_stat("stat_full_ovr");
        wr_stat(32'h4);
        rd_stat("stat_ovr_clr");

        // Full FIFO push+pop: count holds, no overrun, new byte last
        push_pop("pp_full_head", 8'hAA);
        rd_stat("stat_pp_full");
        for (int unsigned i = 0; i < DEPTH; i++) rd_data("drain");
        rd_data("drain_empty");

        // Push+pop on empty: push only, no bypass
        push_pop("pp_empty", 8'h5A);
        rd_data("pp_empty_byte");

        // Pass-through and ignored accesses
        ifc.rdata_in = 32'hDEAD_BEEF;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 14'h0123);
        check("pass_other", ifc.rdata, 32'hDEAD_BEEF);
        push(8'h11);
        drive(1'b0, '0, 1'b1, DATA_ADR, 32'hFFFF_FFFF, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 14'h0042, 32'hFFFF_FFFF, 1'b0, '0);
        rd_stat("stat_ignored_wr");

        // Flush with entries, and flush racing a push
        push(8'h21); push(8'h22);
        wr_stat(32'h8);
        rd_stat("stat_flush");
        m_q.delete();
        drive(1'b1, 8'h33, 1'b1, STAT_ADR, 32'h8, 1'b0, '0);
        rd_stat("stat_flush_push");

        // Overrun clear racing a new overrun
        for (int unsigned i = 0; i < DEPTH; i++) push(8'(i));
        m_ovr = 1'b1;
        drive(1'b1, 8'h99, 1'b1, STAT_ADR, 32'h4, 1'b0, '0);
        rd_stat("stat_ovr_race");

        // Interrupt behaviour
        wr_stat(32'h9);
        push(8'h55);
        check("irq_set", {31'd0, rx_irq}, {31'd0, IRQ_BUILD});
        rd_stat("stat_irq_en");
        rd_data("irq_data");
        check("irq_clr", {31'd0, rx_irq}, 32'd0);
        for (int unsigned i = 0; i < 3; i++) push(8'(8'h70 + i));
        wr_stat(32'h8);
        rd_stat("stat_irq_flush");

        // Asynchronous reset between edges with entries queued
        for (int unsigned i = 0; i < 5; i++) push(8'(8'h80 + i));
        ifc.rdata_in = 32'hCAFE_F00D;
        sb_q.push_back(model_status());
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, STAT_ADR);
        sb_compare("stat_pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pass", ifc.rdata, 32'hCAFE_F00D);
        check("async_rst_irq", {31'd0, rx_irq}, 32'd0);
        #1;
        rst = 1'b0;
        m_q.delete(); m_ovr = 1'b0; m_irq = 1'b0;
        rd_stat("stat_after_async_rst");
        check("stat_after_async_rst_const", ifc.rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
